mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_pkg.sv | 51 +++++
 rtl/lsu_align.sv | 56 +++++
 rtl/mem_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the MEM pipeline stage: EX/MEM and MEM/WB bundles, the
// memory-access FSM states and the RV32 load/store funct3 encodings.
package pipeline_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
    logic [31:0] ImmExt;
  } exmem_t;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
    logic [31:0] ImmExt;
  } memwb_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory port: store byte enables and data
// replication, plus load lane extraction with sign/zero extension.
module lsu_align
  import pipeline_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = ld_rdata[8*gi +: 8];
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_funct3)
      F3_B: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    sel_byte = rd_byte[ld_off];
    sel_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    ld_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   ld_data = {24'd0, sel_byte};
      F3_HU:   ld_data = {16'd0, sel_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: stalls the pipe while a load/store runs over a
// valid/ready data-memory port. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_stage
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  exmem_t      inputs,
  output memwb_t      outputs,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        StallM,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        MisalignM
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;

  logic        mem_op;
  logic        misalign;
  logic        start;
  logic        trap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign mem_op = inputs.MemWrite || (inputs.ResultSrc == RESULT_MEM);

`ifdef MISALIGN_TRAP_EN
  assign misalign = mem_op && is_misaligned(inputs.funct3, inputs.ALUResult[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Stall must be combinational in IDLE so the EX/MEM register holds the op on its first cycle.
  assign start = (state_q == IDLE) && mem_op && !misalign;
  assign trap  = reset_n && (state_q == IDLE) && misalign;

  lsu_align u_lsu_align (
    .st_funct3 (inputs.funct3),
    .st_off    (inputs.ALUResult[1:0]),
    .st_data   (inputs.WriteData),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_rdata  (rdata_q),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = REQ;
          addr_d   = {inputs.ALUResult[31:2], 2'b00};
          be_d     = st_be;
          wdata_d  = st_wdata;
          we_d     = inputs.MemWrite;
          funct3_d = inputs.funct3;
          off_d    = inputs.ALUResult[1:0];
        end
      end
      REQ: begin
        // A response arriving with the handshake is deliberately not sampled.
        if (dmem_req_ready) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          rdata_d = dmem_rsp_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
    end
  end

  assign StallM         = reset_n && (start || (state_q == REQ) || (state_q == WAIT));
  assign dmem_req_valid = (state_q == REQ);
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign MisalignM      = trap;

  always_comb begin
    outputs.ALUResult = inputs.ALUResult;
    outputs.ReadData  = ((state_q == DONE) && !we_q) ? ld_data : 32'd0;
    outputs.RegWrite  = inputs.RegWrite && !trap;
    outputs.ResultSrc = inputs.ResultSrc;
    outputs.PCPlus4   = inputs.PCPlus4;
    outputs.Rd        = inputs.Rd;
    outputs.ImmExt    = inputs.ImmExt;
  end

  assign ALUResultM = inputs.ALUResult;
  assign RdM        = inputs.Rd;
  assign RegWriteM  = outputs.RegWrite;

endmodule
